// File: rtl/dma_axil_bridge_pkg.sv
// dma_axil_bridge_pkg
// Shared types and constants for the IPIF-master to AXI4-Lite bridge:
// bridge state enum, AXI response codes, default timeout length and a
// helper that classifies a response as an error.
package dma_axil_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_DONE,
    S_DRAIN
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/dma_axil_timeout_cnt.sv
// dma_axil_timeout_cnt
// Cycle counter used for the bridge watchdog.
//   i_clk    : clock (rising edge)
//   i_rstn   : synchronous active-low reset
//   i_clear  : clear count to zero (priority over enable)
//   i_en     : count one cycle
//   o_expire : high while enabled and the count equals COUNT-1
module dma_axil_timeout_cnt #(
  parameter int unsigned COUNT = 15
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned W = (COUNT < 2) ? 1 : $clog2(COUNT);

  logic [W-1:0] r_cnt;
  logic         w_at_limit;

  assign w_at_limit = (r_cnt == W'(COUNT - 1));
  assign o_expire   = i_en && w_at_limit;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_limit) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/dma_ipif_axil_bridge.sv
// dma_ipif_axil_bridge
// Slave end of the DMA engine's IPIF single-beat master port. Accepts one
// read or write command, issues it as an AXI4-Lite transaction and returns
// CmdAck / Cmplt / Error pulses plus read data. All outputs are registered.
//   axi_clk, axi_resetn          : clock, synchronous active-low reset
//   IP2Bus_Mst*                  : command side from the DMA engine
//   Bus2IP_Mst*                  : acknowledge / completion / data back
//   M_AXI_*                      : AXI4-Lite master port
// Optional feature: define DMA_AXIL_BRIDGE_TIMEOUT_EN to enable the
// TIMEOUT_CYCLES watchdog; otherwise the bridge waits indefinitely.
module dma_ipif_axil_bridge
  import dma_axil_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              axi_clk,
  input  logic              axi_resetn,
  input  logic              IP2Bus_MstRd_Req,
  input  logic              IP2Bus_MstWr_Req,
  input  logic [ADDR_W-1:0] IP2Bus_Mst_Addr,
  input  logic [3:0]        IP2Bus_Mst_BE,
  input  logic [31:0]       IP2Bus_MstWr_d,
  input  logic              IP2Bus_Mst_Lock,
  input  logic              IP2Bus_Mst_Reset,
  output logic              Bus2IP_Mst_CmdAck,
  output logic              Bus2IP_Mst_Cmplt,
  output logic              Bus2IP_Mst_Error,
  output logic              Bus2IP_Mst_Timeout,
  output logic              Bus2IP_Mst_Rearbitrate,
  output logic [31:0]       Bus2IP_MstRd_d,
  output logic              Bus2IP_MstRd_src_rdy_n,
  output logic              Bus2IP_MstWr_dst_rdy_n,
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [31:0]       M_AXI_WDATA,
  output logic [3:0]        M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [31:0]       M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  state_t              r_state, w_state_nx;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_be;
  logic [31:0]         r_wdata;
  logic                r_is_rd;
  logic                r_awvalid, r_wvalid, r_arvalid, r_bready, r_rready;
  logic                r_cmdack, r_cmplt, r_error, r_timeout;
  logic                r_src_rdy_n, r_dst_rdy_n;
  logic [31:0]         r_rd_d;

  logic                w_awvalid_nx, w_wvalid_nx, w_arvalid_nx;
  logic                w_bready_nx, w_rready_nx;
  logic                w_cmdack_nx, w_cmplt_nx, w_error_nx, w_timeout_nx;
  logic                w_src_rdy_n_nx, w_dst_rdy_n_nx;
  logic [31:0]         w_rd_d_nx;
  logic                w_accept, w_busy, w_expire;
  logic                w_unused;

  assign w_unused = IP2Bus_Mst_Lock;

  assign w_busy = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                  (r_state == S_RD_REQ) || (r_state == S_RD_RESP);

`ifdef DMA_AXIL_BRIDGE_TIMEOUT_EN
  // Count starts the cycle after accept and the pulse is registered, so the
  // counter fires one step early to land Cmplt on cycle TIMEOUT_CYCLES.
  dma_axil_timeout_cnt #(
    .COUNT (TIMEOUT_CYCLES - 1)
  ) u_timeout (
    .i_clk    (axi_clk),
    .i_rstn   (axi_resetn),
    .i_clear  (r_state == S_IDLE),
    .i_en     (w_busy),
    .o_expire (w_expire)
  );
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_state_nx     = r_state;
    w_awvalid_nx   = r_awvalid & ~M_AXI_AWREADY;
    w_wvalid_nx    = r_wvalid  & ~M_AXI_WREADY;
    w_arvalid_nx   = r_arvalid & ~M_AXI_ARREADY;
    w_bready_nx    = 1'b0;
    w_rready_nx    = 1'b0;
    w_cmdack_nx    = 1'b0;
    w_cmplt_nx     = 1'b0;
    w_error_nx     = 1'b0;
    w_timeout_nx   = 1'b0;
    w_src_rdy_n_nx = 1'b1;
    w_dst_rdy_n_nx = 1'b1;
    w_rd_d_nx      = '0;
    w_accept       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (!IP2Bus_Mst_Reset && (IP2Bus_MstRd_Req || IP2Bus_MstWr_Req)) begin
          w_accept    = 1'b1;
          w_cmdack_nx = 1'b1;
          if (IP2Bus_MstRd_Req) begin
            w_arvalid_nx = 1'b1;
            w_state_nx   = S_RD_REQ;
          end else begin
            w_awvalid_nx   = 1'b1;
            w_wvalid_nx    = 1'b1;
            w_dst_rdy_n_nx = 1'b0;
            w_state_nx     = S_WR_REQ;
          end
        end
      end
      S_WR_REQ: begin
        // AW and W retire independently; a low next-VALID means that beat is done.
        if (!w_awvalid_nx && !w_wvalid_nx) begin
          w_state_nx  = S_WR_RESP;
          w_bready_nx = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (r_bready && M_AXI_BVALID) begin
          w_state_nx = S_DONE;
          w_cmplt_nx = 1'b1;
          w_error_nx = resp_is_err(M_AXI_BRESP);
        end else begin
          w_bready_nx = 1'b1;
        end
      end
      S_RD_REQ: begin
        if (!w_arvalid_nx) begin
          w_state_nx  = S_RD_RESP;
          w_rready_nx = 1'b1;
        end
      end
      S_RD_RESP: begin
        if (r_rready && M_AXI_RVALID) begin
          w_state_nx     = S_DONE;
          w_cmplt_nx     = 1'b1;
          w_error_nx     = resp_is_err(M_AXI_RRESP);
          w_src_rdy_n_nx = 1'b0;
          w_rd_d_nx      = M_AXI_RDATA;
        end else begin
          w_rready_nx = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      S_DRAIN: begin
        if (r_is_rd ? (r_rready && M_AXI_RVALID) : (r_bready && M_AXI_BVALID)) begin
          w_state_nx = S_IDLE;
        end else begin
          w_bready_nx = !r_is_rd;
          w_rready_nx = r_is_rd;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    // Abort/timeout override the busy-state result. A response consumed in
    // the same cycle as a soft abort leaves nothing to drain, so go idle.
    if (w_busy && (w_state_nx != S_DONE) && (IP2Bus_Mst_Reset || w_expire)) begin
      w_state_nx  = S_DRAIN;
      w_bready_nx = !r_is_rd;
      w_rready_nx = r_is_rd;
      if (!IP2Bus_Mst_Reset) begin
        w_cmplt_nx   = 1'b1;
        w_error_nx   = 1'b1;
        w_timeout_nx = 1'b1;
      end
    end else if (w_busy && (w_state_nx == S_DONE) && IP2Bus_Mst_Reset) begin
      w_state_nx     = S_IDLE;
      w_cmplt_nx     = 1'b0;
      w_error_nx     = 1'b0;
      w_src_rdy_n_nx = 1'b1;
      w_rd_d_nx      = '0;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_is_rd     <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_cmdack    <= 1'b0;
      r_cmplt     <= 1'b0;
      r_error     <= 1'b0;
      r_timeout   <= 1'b0;
      r_src_rdy_n <= 1'b1;
      r_dst_rdy_n <= 1'b1;
      r_rd_d      <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_awvalid   <= w_awvalid_nx;
      r_wvalid    <= w_wvalid_nx;
      r_arvalid   <= w_arvalid_nx;
      r_bready    <= w_bready_nx;
      r_rready    <= w_rready_nx;
      r_cmdack    <= w_cmdack_nx;
      r_cmplt     <= w_cmplt_nx;
      r_error     <= w_error_nx;
      r_timeout   <= w_timeout_nx;
      r_src_rdy_n <= w_src_rdy_n_nx;
      r_dst_rdy_n <= w_dst_rdy_n_nx;
      r_rd_d      <= w_rd_d_nx;
      if (w_accept) begin
        r_addr  <= IP2Bus_Mst_Addr;
        r_be    <= IP2Bus_Mst_BE;
        r_wdata <= IP2Bus_MstWr_d;
        r_is_rd <= IP2Bus_MstRd_Req;
      end
    end
  end

  assign Bus2IP_Mst_CmdAck      = r_cmdack;
  assign Bus2IP_Mst_Cmplt       = r_cmplt;
  assign Bus2IP_Mst_Error       = r_error;
  assign Bus2IP_Mst_Timeout     = r_timeout;
  assign Bus2IP_Mst_Rearbitrate = 1'b0;
  assign Bus2IP_MstRd_d         = r_rd_d;
  assign Bus2IP_MstRd_src_rdy_n = r_src_rdy_n;
  assign Bus2IP_MstWr_dst_rdy_n = r_dst_rdy_n;
  assign M_AXI_AWADDR           = r_addr;
  assign M_AXI_AWVALID          = r_awvalid;
  assign M_AXI_WDATA            = r_wdata;
  assign M_AXI_WSTRB            = r_be;
  assign M_AXI_WVALID           = r_wvalid;
  assign M_AXI_BREADY           = r_bready;
  assign M_AXI_ARADDR           = r_addr;
  assign M_AXI_ARVALID          = r_arvalid;
  assign M_AXI_RREADY           = r_rready;

endmodule

// File: tb/tb_dma_ipif_axil_bridge.sv
// tb_dma_ipif_axil_bridge
// Self-checking bench for dma_ipif_axil_bridge. Each transaction's expected
// per-cycle control outputs are derived arithmetically from the slave delays
// chosen for it (handshake cycles, response cycle, completion cycle).
module tb_dma_ipif_axil_bridge;

  logic        clk = 1'b0;
  logic        axi_resetn;
  logic        IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Lock, IP2Bus_Mst_Reset;
  logic [31:0] IP2Bus_Mst_Addr, IP2Bus_MstWr_d;
  logic [3:0]  IP2Bus_Mst_BE;
  logic        Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error, Bus2IP_Mst_Timeout;
  logic        Bus2IP_Mst_Rearbitrate, Bus2IP_MstRd_src_rdy_n, Bus2IP_MstWr_dst_rdy_n;
  logic [31:0] Bus2IP_MstRd_d;
  logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dma_ipif_axil_bridge #(
    .TIMEOUT_CYCLES (16),
    .ADDR_W         (32)
  ) dut (
    .axi_clk                (clk),
    .axi_resetn             (axi_resetn),
    .IP2Bus_MstRd_Req       (IP2Bus_MstRd_Req),
    .IP2Bus_MstWr_Req       (IP2Bus_MstWr_Req),
    .IP2Bus_Mst_Addr        (IP2Bus_Mst_Addr),
    .IP2Bus_Mst_BE          (IP2Bus_Mst_BE),
    .IP2Bus_MstWr_d         (IP2Bus_MstWr_d),
    .IP2Bus_Mst_Lock        (IP2Bus_Mst_Lock),
    .IP2Bus_Mst_Reset       (IP2Bus_Mst_Reset),
    .Bus2IP_Mst_CmdAck      (Bus2IP_Mst_CmdAck),
    .Bus2IP_Mst_Cmplt       (Bus2IP_Mst_Cmplt),
    .Bus2IP_Mst_Error       (Bus2IP_Mst_Error),
    .Bus2IP_Mst_Timeout     (Bus2IP_Mst_Timeout),
    .Bus2IP_Mst_Rearbitrate (Bus2IP_Mst_Rearbitrate),
    .Bus2IP_MstRd_d         (Bus2IP_MstRd_d),
    .Bus2IP_MstRd_src_rdy_n (Bus2IP_MstRd_src_rdy_n),
    .Bus2IP_MstWr_dst_rdy_n (Bus2IP_MstWr_dst_rdy_n),
    .M_AXI_AWADDR           (M_AXI_AWADDR),
    .M_AXI_AWVALID          (M_AXI_AWVALID),
    .M_AXI_AWREADY          (M_AXI_AWREADY),
    .M_AXI_WDATA            (M_AXI_WDATA),
    .M_AXI_WSTRB            (M_AXI_WSTRB),
    .M_AXI_WVALID           (M_AXI_WVALID),
    .M_AXI_WREADY           (M_AXI_WREADY),
    .M_AXI_BRESP            (M_AXI_BRESP),
    .M_AXI_BVALID           (M_AXI_BVALID),
    .M_AXI_BREADY           (M_AXI_BREADY),
    .M_AXI_ARADDR           (M_AXI_ARADDR),
    .M_AXI_ARVALID          (M_AXI_ARVALID),
    .M_AXI_ARREADY          (M_AXI_ARREADY),
    .M_AXI_RDATA            (M_AXI_RDATA),
    .M_AXI_RRESP            (M_AXI_RRESP),
    .M_AXI_RVALID           (M_AXI_RVALID),
    .M_AXI_RREADY           (M_AXI_RREADY)
  );

  // {CmdAck, Cmplt, Error, Timeout, src_rdy_n, dst_rdy_n, AWV, WV, BRDY, ARV, RRDY}
  function automatic logic [10:0] obs_vec();
    return {Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error, Bus2IP_Mst_Timeout,
            Bus2IP_MstRd_src_rdy_n, Bus2IP_MstWr_dst_rdy_n, M_AXI_AWVALID, M_AXI_WVALID,
            M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One command, cycle 0 = Req presented in IDLE. Slave readies/responses are
  // single-cycle pulses placed on the cycles the protocol says the bridge is
  // waiting for them.
  task automatic txn(input bit rd, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata, input int aw_dly, input int w_dly,
                     input int ar_dly, input int rsp_dly, input logic [1:0] resp,
                     input logic [31:0] rdata, input bit hold_wr, input int abort_c,
                     input int to_c);
    int aw_hs, w_hs, a_hs, rs_start, rs_hs, cm, end_c;
    bit to, rerr;
    logic [10:0] ev;
    aw_hs = 0; w_hs = 0; a_hs = 0;
    to = (to_c > 0);
    if (rd) begin
      a_hs     = 1 + ar_dly;
      rs_start = a_hs + 1;
    end else begin
      aw_hs    = 1 + aw_dly;
      w_hs     = 1 + w_dly;
      rs_start = ((aw_hs > w_hs) ? aw_hs : w_hs) + 1;
    end
    rs_hs = rs_start + rsp_dly;
    cm    = to ? to_c : ((abort_c > 0) ? -1 : rs_hs + 1);
    end_c = (to || abort_c > 0) ? rs_hs : cm;
    rerr  = to || (resp == 2'b10) || (resp == 2'b11);
    for (int c = 0; c <= end_c; c++) begin
      @(negedge clk);
      ev = {(c == 1), (c == cm), ((c == cm) && rerr), ((c == cm) && to),
            !((c == cm) && rd && !to), !((c == 1) && !rd),
            (!rd && c >= 1 && c <= aw_hs), (!rd && c >= 1 && c <= w_hs),
            (!rd && c >= rs_start && c <= rs_hs),
            (rd && c >= 1 && c <= a_hs), (rd && c >= rs_start && c <= rs_hs)};
      chk($sformatf("ctl c%0d rd%0d", c, rd), {21'b0, obs_vec()}, {21'b0, ev});
      if (!rd && c == aw_hs) chk("awaddr", M_AXI_AWADDR, addr);
      if (!rd && c == w_hs) begin
        chk("wdata", M_AXI_WDATA, wdata);
        chk("wstrb", {28'b0, M_AXI_WSTRB}, {28'b0, be});
      end
      if (rd && c == a_hs) chk("araddr", M_AXI_ARADDR, addr);
      if (rd && !to && c == cm) chk("rd_d", Bus2IP_MstRd_d, rdata);
      IP2Bus_MstRd_Req = rd && (c == 0);
      IP2Bus_MstWr_Req = (!rd && (c == 0)) || hold_wr;
      IP2Bus_Mst_Reset = (c == abort_c);
      if (c == 0) begin
        IP2Bus_Mst_Addr = addr; IP2Bus_Mst_BE = be; IP2Bus_MstWr_d = wdata;
      end else begin
        IP2Bus_Mst_Addr = $urandom; IP2Bus_Mst_BE = 4'($urandom); IP2Bus_MstWr_d = $urandom;
      end
      M_AXI_AWREADY = !rd && (c == aw_hs);
      M_AXI_WREADY  = !rd && (c == w_hs);
      M_AXI_ARREADY = rd && (c == a_hs);
      M_AXI_BVALID  = !rd && (c == rs_hs);
      M_AXI_BRESP   = resp;
      M_AXI_RVALID  = rd && (c == rs_hs);
      M_AXI_RRESP   = resp;
      M_AXI_RDATA   = (c == rs_hs) ? rdata : $urandom;
    end
  endtask

  initial begin
    axi_resetn = 1'b0;
    IP2Bus_MstRd_Req = 1'b0; IP2Bus_MstWr_Req = 1'b0; IP2Bus_Mst_Lock = 1'b0;
    IP2Bus_Mst_Reset = 1'b0; IP2Bus_Mst_Addr = '0; IP2Bus_Mst_BE = '0; IP2Bus_MstWr_d = '0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ctl", {21'b0, obs_vec()}, {21'b0, 11'b000011_00000});
    chk("reset awaddr", M_AXI_AWADDR, 32'h0);
    chk("reset wdata", M_AXI_WDATA, 32'h0);
    chk("reset rd_d", Bus2IP_MstRd_d, 32'h0);
    chk("rearb", {31'b0, Bus2IP_Mst_Rearbitrate}, 32'h0);
    axi_resetn = 1'b1;

    // Zero-wait write, OKAY.
    txn(0, 32'h7A00_0010, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, 0, 2'b00, 32'h0, 0, -1, 0);
    // Read with 5-cycle ARREADY delay, SLVERR.
    txn(1, 32'h7A00_0020, 4'hF, 32'h0, 0, 0, 5, 0, 2'b10, 32'h1234_5678, 0, -1, 0);
    // W accepted three cycles before AW.
    txn(0, 32'h7A00_0030, 4'h3, 32'hCAFE_F00D, 3, 0, 0, 1, 2'b00, 32'h0, 0, -1, 0);
    // Read and write requested together: read first, write held until IDLE.
    txn(1, 32'h7A00_0040, 4'hF, 32'h0, 0, 0, 0, 0, 2'b00, 32'hA5A5_5A5A, 1, -1, 0);
    txn(0, 32'h7A00_0044, 4'hC, 32'h0BAD_F00D, 0, 2, 0, 0, 2'b11, 32'h0, 0, -1, 0);
    // Soft abort in RD_RESP: beat drained, no completion.
    txn(1, 32'h7A00_0050, 4'hF, 32'h0, 0, 0, 1, 3, 2'b00, 32'h5555_AAAA, 0, 4, 0);
`ifdef DMA_AXIL_BRIDGE_TIMEOUT_EN
    // Slave withholds BVALID past the 16-cycle watchdog; late response drained.
    txn(0, 32'h7A00_0060, 4'hF, 32'h1111_2222, 0, 0, 0, 18, 2'b10, 32'h0, 0, -1, 16);
`endif
    for (int i = 0; i < 20; i++) begin
      txn(1'($urandom), $urandom, 4'($urandom), $urandom, int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          2'($urandom), $urandom, 0, -1, 0);
    end

    // axi_resetn mid-write returns outputs to reset values at once.
    @(negedge clk);
    IP2Bus_MstWr_Req = 1'b1; IP2Bus_Mst_Addr = 32'h7A00_0070; IP2Bus_MstWr_d = 32'h7777_0000;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_RVALID = 1'b0;
    M_AXI_ARREADY = 1'b0; IP2Bus_Mst_Reset = 1'b0; IP2Bus_MstRd_Req = 1'b0;
    @(negedge clk);
    IP2Bus_MstWr_Req = 1'b0;
    chk("pre-reset awvalid", {31'b0, M_AXI_AWVALID}, 32'h1);
    axi_resetn = 1'b0;
    @(negedge clk);
    chk("midreset ctl", {21'b0, obs_vec()}, {21'b0, 11'b000011_00000});
    chk("midreset awaddr", M_AXI_AWADDR, 32'h0);
    axi_resetn = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_ipif_axil_bridge.md
# dma_ipif_axil_bridge

Slave end of the DMA engine's IPIF-style single-beat master port (IP2Bus_Mst*/Bus2IP_Mst*). Accepts one read or write command at a time from the DMA engine, issues it as an AXI4-Lite transaction on the register bus, and returns CmdAck, data and Cmplt/Error pulses. Sits between the DMA engine and the AXI-Lite interconnect in the axi_clk domain.

## Interface
- TIMEOUT_CYCLES, 1024: cycles from accept to Cmplt before forced timeout; used only with TIMEOUT_EN.
- ADDR_W, 32: address width on both sides.
- axi_clk in 1: sole clock; all logic rising-edge.
- axi_resetn in 1: reset; synchronous, active-low.
- IP2Bus_MstRd_Req / IP2Bus_MstWr_Req in 1: read / write request, level.
- IP2Bus_Mst_Addr in ADDR_W, IP2Bus_Mst_BE in 4, IP2Bus_MstWr_d in 32: command; valid while Req high.
- IP2Bus_Mst_Lock in 1: ignored.
- IP2Bus_Mst_Reset in 1: soft abort, see Operation.
- Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error, Bus2IP_Mst_Timeout out 1: one-cycle pulses.
- Bus2IP_Mst_Rearbitrate out 1: tied 0.
- Bus2IP_MstRd_d out 32; Bus2IP_MstRd_src_rdy_n out 1; Bus2IP_MstWr_dst_rdy_n out 1.
- M_AXI_AWADDR out ADDR_W, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1.
- M_AXI_WDATA out 32, M_AXI_WSTRB out 4, M_AXI_WVALID out 1, M_AXI_WREADY in 1.
- M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1.
- M_AXI_ARADDR out ADDR_W, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1.
- M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE, DRAIN.
- IDLE: Req high -> register Addr, BE, MstWr_d; read wins if both high. -> RD_REQ or WR_REQ.
- WR_REQ: AWVALID and WVALID both high; each drops independently on its handshake (aw_done/w_done flags); both done -> WR_RESP.
- WR_RESP: BREADY=1; on BVALID capture BRESP -> DONE.
- RD_REQ: ARVALID=1 until ARREADY -> RD_RESP. RD_RESP: RREADY=1; on RVALID register RDATA, RRESP -> DONE.
- DONE (one cycle): Cmplt=1, Error=resp[1] (SLVERR/DECERR); read: MstRd_src_rdy_n=0, MstRd_d=captured RDATA. -> IDLE.
- Req ignored from accept until IDLE re-entry; master must deassert Req on CmdAck.
- IP2Bus_Mst_Reset high: in IDLE, no accept; in any busy state -> DRAIN without Cmplt.
- DRAIN: keep any pending VALIDs until handshake, BREADY/RREADY=1; on response discard -> IDLE. No IPIF pulses.
- All outputs registered. Reset values: all VALID/READY 0, CmdAck/Cmplt/Error/Timeout 0, src_rdy_n/dst_rdy_n 1, data/addr outputs 0, state IDLE.

## Timing
- Cycle 0: Req seen in IDLE. Cycle 1: CmdAck=1; AWVALID/WVALID or ARVALID=1; write also MstWr_dst_rdy_n=0 (data already captured).
- Response handshake at cycle N -> Cmplt at N+1 -> IDLE at N+2; new Req accepted at N+2 earliest.
- Zero-wait slave (READY high, response one cycle after address): read Cmplt cycle 3, write Cmplt cycle 3.
- AW before W, W before AW, or same cycle all legal; WR_RESP entered cycle after the later one.
- VALID never drops before handshake except via reset.
- axi_resetn low mid-transaction: immediate return to reset values; interconnect reset is shared.

## Configuration
- DMA_AXIL_BRIDGE_TIMEOUT_EN defined: counter starts at accept; reaching TIMEOUT_CYCLES while not in DONE/IDLE -> one-cycle Cmplt=1, Error=1, Timeout=1 (read: src_rdy_n stays 1), then DRAIN. Counter clears on IDLE.
- Undefined: no counter; Timeout tied 0; bridge waits indefinitely.

## Structure
- Package dma_axil_bridge_pkg: state enum, AXI resp constants (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11), default TIMEOUT_CYCLES.
- Sub-module dma_axil_timeout_cnt (clear, enable, expire pulse), instantiated only under DMA_AXIL_BRIDGE_TIMEOUT_EN.

## Test plan
- Write addr 0x7A00_0010, BE 0xF, data 0xDEADBEEF, zero-wait slave, BRESP OKAY -> AWADDR/WDATA/WSTRB match, CmdAck cycle 1, Cmplt cycle 3, Error 0.
- Read 0x7A00_0020, slave RDATA 0x12345678 after 5-cycle ARREADY delay, RRESP SLVERR -> src_rdy_n=0 with data 0x12345678, Cmplt=Error=1 same cycle.
- Write with WREADY 3 cycles before AWREADY -> WVALID drops after W handshake, AWVALID holds; exactly one AW and one W beat.
- Read and write Req same cycle -> read issued first; write accepted after read Cmplt.
- With TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never asserts BVALID -> Cmplt/Error/Timeout pulse at cycle 16; late BVALID drained silently; next Req accepted.
- Assert IP2Bus_Mst_Reset in RD_RESP, then RVALID -> no Cmplt, RREADY consumes beat, return to IDLE.
